divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 18 +
 rtl/divider_if.sv | 27 ++
 rtl/div_step.sv | 30 +++
 rtl/divider.sv | 128 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the iterative restoring divider.
package div_pkg;

   localparam int DIV_SIZE  = 16;
   localparam int DIV_CNT_W = $clog2(DIV_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Step-counter width for an arbitrary operand width.
   function automatic int div_cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between a divider client and the divider.
interface divider_if
   import div_pkg::*;
#(
   parameter int SIZE = DIV_SIZE
) ();

   logic            start;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic [SIZE-1:0] q;
   logic [SIZE-1:0] r;
   logic            busy;
   logic            done;
   logic            div_zero;

   modport master (
      output start, a, b,
      input  q, r, busy, done, div_zero
   );

   modport slave (
      input  start, a, b,
      output q, r, busy, done, div_zero
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int SIZE = DIV_SIZE
) (
   input  logic [SIZE:0]   rem_in,
   input  logic            dbit,
   input  logic [SIZE-1:0] divisor,
   output logic [SIZE:0]   rem_out,
   output logic            qbit
);

   logic [SIZE:0] shifted_s;
   logic [SIZE:0] divisor_s;

   // Shift, compare and conditionally subtract.
   always_comb begin
      shifted_s = (rem_in << 1) | {{SIZE{1'b0}}, dbit};
      divisor_s = {1'b0, divisor};
      if (shifted_s >= divisor_s) begin
         rem_out = shifted_s - divisor_s;
         qbit    = 1'b1;
      end else begin
         rem_out = shifted_s;
         qbit    = 1'b0;
      end
   end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider: one restoring step per clock, SIZE steps per operation.
module divider
   import div_pkg::*;
#(
   parameter int SIZE = DIV_SIZE
) (
   input  logic      clk,
   input  logic      rst,
   divider_if.slave  bus
);

   localparam int             CNT_W    = div_cnt_width(SIZE);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SIZE - 1);

   div_state_e       state_r;
   div_state_e       state_s;
   logic [SIZE-1:0]  a_r;
   logic [SIZE-1:0]  b_r;
   logic [SIZE:0]    rem_r;
   logic [SIZE-1:0]  quo_r;
   logic [CNT_W-1:0] cnt_r;
   logic [SIZE-1:0]  q_r;
   logic [SIZE-1:0]  r_r;
   logic             busy_r;
   logic             done_r;
   logic             div_zero_r;
   logic             accept_s;
   logic             last_s;
   logic [SIZE:0]    step_rem_s;
   logic             step_qbit_s;

   div_step #(.SIZE(SIZE)) u_step (
      .rem_in  (rem_r),
      .dbit    (a_r[SIZE-1]),
      .divisor (b_r),
      .rem_out (step_rem_s),
      .qbit    (step_qbit_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; a zero divisor skips CALC entirely.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s = 1'b1;
               if (bus.b == '0) begin
                  state_s = DONE;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == LAST_STEP) begin
               last_s  = 1'b1;
               state_s = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r        <= '0;
         b_r        <= '0;
         rem_r      <= '0;
         quo_r      <= '0;
         cnt_r      <= '0;
         q_r        <= '0;
         r_r        <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         busy_r <= (state_s == CALC);
         done_r <= (state_s == DONE);
         if (accept_s) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            rem_r      <= '0;
            quo_r      <= '0;
            cnt_r      <= '0;
            div_zero_r <= 1'b0;
            if (bus.b == '0) begin
               q_r        <= {SIZE{1'b1}};
               r_r        <= bus.a;
               div_zero_r <= 1'b1;
            end
         end else if (state_r == CALC) begin
            a_r   <= a_r << 1;
            rem_r <= step_rem_s;
            quo_r <= (quo_r << 1) | {{(SIZE-1){1'b0}}, step_qbit_s};
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
               // The final remainder is below the divisor, so its top bit is always clear.
               q_r <= (quo_r << 1) | {{(SIZE-1){1'b0}}, step_qbit_s};
               r_r <= step_rem_s[SIZE-1:0];
            end
         end
      end
   end

   assign bus.q        = q_r;
   assign bus.r        = r_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;

endmodule
